// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared opcode map, FSM state encoding and shifter mode codes
//               for the sequential ALU.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Opcode map (unchanged from the combinational ALU)
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SHL = 3'b100;
    localparam logic [2:0] OP_SHR = 3'b101;
    localparam logic [2:0] OP_SRA = 3'b110;
    localparam logic [2:0] OP_XOR = 3'b111;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // One-bit shifter modes
    localparam logic [1:0] SH_SHL = 2'd0;
    localparam logic [1:0] SH_SHR = 2'd1;
    localparam logic [1:0] SH_SRA = 2'd2;

    // True for the three opcodes that run through the iterative shifter
    function automatic logic is_shift(input logic [2:0] op);
        return (op == OP_SHL) || (op == OP_SHR) || (op == OP_SRA);
    endfunction

    // Map a shift opcode onto the shifter mode code
    function automatic logic [1:0] shift_mode(input logic [2:0] op);
        logic [1:0] m;
        case (op)
            OP_SHR:  m = SH_SHR;
            OP_SRA:  m = SH_SRA;
            default: m = SH_SHL;
        endcase
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_shift_step.sv
`default_nettype none
// ============================================================================
// Module      : alu_shift_step
// Description : Combinational one-bit shifter (logical left, logical right,
//               arithmetic right). Flags a sign-bit change on left shifts.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_shift_step
    import alu_pkg::*;
#(
    parameter int nIO = 8
) (
    input  logic [nIO-1:0] value,
    input  logic [1:0]     mode,
    output logic [nIO-1:0] shifted,
    output logic           sign_chg
);

    // Single shift step; sign change only matters for left shifts
    always_comb begin
        shifted  = value;
        sign_chg = 1'b0;
        case (mode)
            SH_SHL: begin
                shifted  = {value[nIO-2:0], 1'b0};
                sign_chg = value[nIO-1] ^ value[nIO-2];
            end
            SH_SHR:  shifted = {1'b0, value[nIO-1:1]};
            SH_SRA:  shifted = {value[nIO-1], value[nIO-1:1]};
            default: shifted = value;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq
// Description : Handshaked sequential ALU. Single-cycle ADD/SUB/AND/OR/XOR,
//               iterative one-bit-per-cycle SHL/SHR/SRA, registered Z/OV held
//               until the consumer accepts them.
// Config      : ALU_SAT_EN - saturating ADD/SUB and SHL on signed overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq
    import alu_pkg::*;
#(
    parameter int nIO = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [nIO-1:0] A,
    input  logic [nIO-1:0] B,
    input  logic [2:0]     OP,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [nIO-1:0] Z,
    output logic           OV
);

    localparam int SHW = $clog2(nIO) + 1;

    // Amounts at or above the width are clamped to the width
    localparam logic [SHW-1:0] c_nio = SHW'(nIO);

`ifdef ALU_SAT_EN
    localparam logic [nIO-1:0] c_max = {1'b0, {(nIO-1){1'b1}}};
    localparam logic [nIO-1:0] c_min = {1'b1, {(nIO-1){1'b0}}};
`endif

    logic [1:0]     r_state;
    logic [nIO-1:0] r_work;
    logic [SHW-1:0] r_cnt;
    logic [1:0]     r_mode;
    logic           r_shov;
    logic [nIO-1:0] r_z;
    logic           r_ov;
    logic           r_out_valid;
    logic           r_in_ready;
`ifdef ALU_SAT_EN
    logic           r_sign;
`endif

    logic           w_accept;
    logic [SHW-1:0] w_k;
    logic [SHW-1:0] w_cnt_init;
    logic [nIO-1:0] w_sum;
    logic [nIO-1:0] w_dif;
    logic [nIO-1:0] w_alu_z;
    logic           w_alu_ov;
    logic [nIO-1:0] w_step;
    logic           w_chg;
    logic           w_fin_ov;
    logic [nIO-1:0] w_fin_z;

    assign w_accept   = in_valid && r_in_ready;
    assign w_k        = B[SHW-1:0];
    assign w_cnt_init = (w_k > c_nio) ? c_nio : w_k;
    assign w_sum      = A + B;
    assign w_dif      = A - B;

    // Single-cycle result for the non-shift ops (shift ops with k=0 pass A)
    always_comb begin
        w_alu_z  = A;
        w_alu_ov = 1'b0;
        case (OP)
            OP_ADD: begin
                w_alu_z  = w_sum;
                w_alu_ov = (A[nIO-1] == B[nIO-1]) && (w_sum[nIO-1] != A[nIO-1]);
            end
            OP_SUB: begin
                w_alu_z  = w_dif;
                w_alu_ov = (A[nIO-1] != B[nIO-1]) && (w_dif[nIO-1] != A[nIO-1]);
            end
            OP_AND:  w_alu_z = A & B;
            OP_OR:   w_alu_z = A | B;
            OP_XOR:  w_alu_z = A ^ B;
            default: w_alu_z = A;
        endcase
`ifdef ALU_SAT_EN
        // Overflow direction follows the sign of A for both ADD and SUB
        if (w_alu_ov)
            w_alu_z = A[nIO-1] ? c_min : c_max;
`endif
    end

    alu_shift_step #(
        .nIO      (nIO)
    ) u_shift_step (
        .value    (r_work),
        .mode     (r_mode),
        .shifted  (w_step),
        .sign_chg (w_chg)
    );

    // Result of the final shift step; sticky OV only ever sets for SHL
    always_comb begin
        w_fin_ov = r_shov | w_chg;
        w_fin_z  = w_step;
`ifdef ALU_SAT_EN
        if (w_fin_ov)
            w_fin_z = r_sign ? c_min : c_max;
`endif
    end

    // Control FSM and all registered datapath/outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_work      <= '0;
            r_cnt       <= '0;
            r_mode      <= SH_SHL;
            r_shov      <= 1'b0;
            r_z         <= '0;
            r_ov        <= 1'b0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
`ifdef ALU_SAT_EN
            r_sign      <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_in_ready <= 1'b0;
                        if (is_shift(OP) && (w_k != '0)) begin
                            r_work  <= A;
                            r_cnt   <= w_cnt_init;
                            r_mode  <= shift_mode(OP);
                            r_shov  <= 1'b0;
`ifdef ALU_SAT_EN
                            r_sign  <= A[nIO-1];
`endif
                            r_state <= ST_SHIFT;
                        end else begin
                            r_z         <= w_alu_z;
                            r_ov        <= w_alu_ov;
                            r_out_valid <= 1'b1;
                            r_state     <= ST_DONE;
                        end
                    end
                end
                ST_SHIFT: begin
                    r_work <= w_step;
                    r_shov <= w_fin_ov;
                    r_cnt  <= r_cnt - 1'b1;
                    if (r_cnt == SHW'(1)) begin
                        r_z         <= w_fin_z;
                        r_ov        <= w_fin_ov;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign Z         = r_z;
    assign OV        = r_ov;

endmodule
`default_nettype wire
